// File: rtl/pwm_dead_time_pkg.sv
// Shared definitions for the PWM dead-time output stage: channel FSM
// state encodings and default widths.
package pwm_dead_time_pkg;

    localparam int unsigned CHANNELS_DEFAULT   = 16;
    localparam int unsigned DEAD_WIDTH_DEFAULT = 8;

    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_LOW    = 3'd1;
    localparam logic [2:0] ST_DEAD_H = 3'd2;
    localparam logic [2:0] ST_HIGH   = 3'd3;
    localparam logic [2:0] ST_DEAD_L = 3'd4;

endpackage

// File: rtl/pwm_dead_time_channel.sv
// One complementary output channel: Moore FSM with dead-time counter,
// outputs registered from the next-state decode.
module pwm_dead_time_channel
    import pwm_dead_time_pkg::*;
#(
    parameter int unsigned DEAD_WIDTH = DEAD_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pwm_in,
    input  logic                  pwm_en_in,
    input  logic [DEAD_WIDTH-1:0] dead_time,
    input  logic                  fault_latched,
    output logic                  out_high,
    output logic                  out_low,
    output logic                  out_en
);

    logic [2:0]            state, state_nxt;
    logic [DEAD_WIDTH-1:0] cnt, cnt_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!pwm_en_in || fault_latched) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF: state_nxt = ST_LOW;
                ST_LOW: begin
                    if (pwm_in) begin
                        if (dead_time == '0) begin
                            state_nxt = ST_HIGH;
                        end else begin
                            state_nxt = ST_DEAD_H;
                            cnt_nxt   = dead_time - DEAD_WIDTH'(1);
                        end
                    end
                end
                ST_DEAD_H: begin
                    if (!pwm_in)          state_nxt = ST_LOW;
                    else if (cnt == '0)   state_nxt = ST_HIGH;
                    else                  cnt_nxt   = cnt - DEAD_WIDTH'(1);
                end
                ST_HIGH: begin
                    if (!pwm_in) begin
                        if (dead_time == '0) begin
                            state_nxt = ST_LOW;
                        end else begin
                            state_nxt = ST_DEAD_L;
                            cnt_nxt   = dead_time - DEAD_WIDTH'(1);
                        end
                    end
                end
                ST_DEAD_L: begin
                    if (pwm_in)           state_nxt = ST_HIGH;
                    else if (cnt == '0)   state_nxt = ST_LOW;
                    else                  cnt_nxt   = cnt - DEAD_WIDTH'(1);
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    // Outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_OFF;
            cnt      <= '0;
            out_high <= 1'b0;
            out_low  <= 1'b0;
            out_en   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            out_high <= (state_nxt == ST_HIGH);
            out_low  <= (state_nxt == ST_LOW);
            out_en   <= (state_nxt != ST_OFF);
        end
    end

endmodule

// File: rtl/pwm_dead_time.sv
// PWM dead-time insertion and fault shutdown for CHANNELS complementary pairs.
// Define PWM_DEAD_TIME_FAULT_SYNC_EN to pass fault through a 2-flop synchronizer.
module pwm_dead_time
    import pwm_dead_time_pkg::*;
#(
    parameter int unsigned CHANNELS   = CHANNELS_DEFAULT,
    parameter int unsigned DEAD_WIDTH = DEAD_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   pwm_in,
    input  logic [CHANNELS-1:0]   pwm_en_in,
    input  logic [DEAD_WIDTH-1:0] dead_time,
    input  logic                  fault,
    input  logic                  fault_clear,
    output logic [CHANNELS-1:0]   out_high,
    output logic [CHANNELS-1:0]   out_low,
    output logic [CHANNELS-1:0]   out_en,
    output logic                  fault_irq
);

    logic fault_q;
    logic fault_latched;

`ifdef PWM_DEAD_TIME_FAULT_SYNC_EN
    logic [1:0] fault_sync;

    always_ff @(posedge clk) begin
        if (!rst) fault_sync <= '0;
        else      fault_sync <= {fault_sync[0], fault};
    end

    assign fault_q = fault_sync[1];
`else
    assign fault_q = fault;
`endif

    // Set has priority over clear so a persistent fault cannot be cleared.
    always_ff @(posedge clk) begin
        if (!rst)             fault_latched <= 1'b0;
        else if (fault_q)     fault_latched <= 1'b1;
        else if (fault_clear) fault_latched <= 1'b0;
    end

    assign fault_irq = fault_latched;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        pwm_dead_time_channel #(
            .DEAD_WIDTH (DEAD_WIDTH)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .pwm_in        (pwm_in[ch]),
            .pwm_en_in     (pwm_en_in[ch]),
            .dead_time     (dead_time),
            .fault_latched (fault_latched),
            .out_high      (out_high[ch]),
            .out_low       (out_low[ch]),
            .out_en        (out_en[ch])
        );
    end

endmodule

// File: tb/tb_pwm_dead_time.sv
// Directed self-checking bench for pwm_dead_time (default 16 channels, 8-bit dead time).
module tb_pwm_dead_time;

    localparam int unsigned CHANNELS   = 16;
    localparam int unsigned DEAD_WIDTH = 8;
`ifdef PWM_DEAD_TIME_FAULT_SYNC_EN
    localparam int unsigned FAULT_LAT = 4;
`else
    localparam int unsigned FAULT_LAT = 2;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [CHANNELS-1:0]   pwm_in;
    logic [CHANNELS-1:0]   pwm_en_in;
    logic [DEAD_WIDTH-1:0] dead_time;
    logic                  fault;
    logic                  fault_clear;
    logic [CHANNELS-1:0]   out_high;
    logic [CHANNELS-1:0]   out_low;
    logic [CHANNELS-1:0]   out_en;
    logic                  fault_irq;

    int unsigned         n_checks = 0;
    int unsigned         n_pass   = 0;
    logic [CHANNELS-1:0] overlap_acc = '0;
    logic                seen_high;

    pwm_dead_time #(
        .CHANNELS   (CHANNELS),
        .DEAD_WIDTH (DEAD_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .pwm_en_in   (pwm_en_in),
        .dead_time   (dead_time),
        .fault       (fault),
        .fault_clear (fault_clear),
        .out_high    (out_high),
        .out_low     (out_low),
        .out_en      (out_en),
        .fault_irq   (fault_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    // Advance one cycle; inputs set after this are sampled on the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        overlap_acc |= (out_high & out_low);
    endtask

    initial begin
        rst         = 1'b0;
        pwm_in      = '1;
        pwm_en_in   = '1;
        dead_time   = '0;
        fault       = 1'b0;
        fault_clear = 1'b0;
        tick();
        tick();
        check("rst_high", out_high, 0);
        check("rst_low",  out_low,  0);
        check("rst_en",   out_en,   0);
        check("rst_irq",  fault_irq, 0);

        rst = 1'b1;
        tick();
        check("rel_low", out_low, 32'h0000_FFFF);
        check("rel_en",  out_en,  32'h0000_FFFF);
        check("rel_high", out_high, 0);
        pwm_in = '0;
        tick();

        // Dead time of 3 on channel 0, rising then falling edge.
        dead_time = 8'd3;
        pwm_in[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("dt_rise_high_%0d", k), out_high[0], (k >= 4) ? 1 : 0);
            check($sformatf("dt_rise_low_%0d", k),  out_low[0],  0);
        end
        check("dt_others_low", out_low[15:1], 32'h7FFF);
        check("dt_en0", out_en[0], 1);
        pwm_in[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("dt_fall_high_%0d", k), out_high[0], 0);
            check($sformatf("dt_fall_low_%0d", k),  out_low[0],  (k >= 4) ? 1 : 0);
        end

        // Two-cycle pulse against a dead time of 5 is swallowed.
        dead_time = 8'd5;
        seen_high = 1'b0;
        pwm_in[1] = 1'b1;
        tick();
        check("gl_low_a", out_low[1], 0);
        tick();
        check("gl_low_b", out_low[1], 0);
        seen_high |= out_high[1];
        pwm_in[1] = 1'b0;
        tick();
        check("gl_low_back", out_low[1], 1);
        for (int k = 0; k < 8; k++) begin
            seen_high |= out_high[1];
            tick();
        end
        check("gl_no_high", seen_high, 0);

        // Zero dead time: follows pwm_in with one cycle latency.
        dead_time = 8'd0;
        for (int k = 0; k < 8; k++) begin
            pwm_in[2] = (k % 2 == 0);
            tick();
            check($sformatf("zd_high_%0d", k), out_high[2], (k % 2 == 0) ? 1 : 0);
            check($sformatf("zd_low_%0d", k),  out_low[2],  (k % 2 == 0) ? 0 : 1);
        end
        pwm_in[2] = 1'b0;
        tick();

        // Fault while channels 4..7 are driving high.
        dead_time = 8'd2;
        pwm_in[7:4] = 4'hF;
        repeat (4) tick();
        check("flt_pre_high", out_high[7:4], 4'hF);
        fault = 1'b1;
        repeat (FAULT_LAT - 1) tick();
        check("flt_irq_set", fault_irq, 1);
        check("flt_still_high", out_high[7:4], 4'hF);
        tick();
        check("flt_off_high", out_high, 0);
        check("flt_off_low",  out_low,  0);
        check("flt_off_en",   out_en,   0);
        fault_clear = 1'b1;
        repeat (3) tick();
        check("flt_both_latched", fault_irq, 1);
        fault_clear = 1'b0;
        fault = 1'b0;
        repeat (3) tick();
        check("flt_hold", fault_irq, 1);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("flt_cleared", fault_irq, 0);
        check("flt_clr_en", out_en, 0);
        tick();
        check("flt_resume_low", out_low, 32'h0000_FFFF);
        check("flt_resume_nohigh", out_high, 0);
        tick();
        check("flt_dead_nohigh", out_high[7:4], 0);
        pwm_in[7:4] = 4'h0;
        repeat (4) tick();

        // Enable dropped part way through a long dead time on channel 3.
        dead_time = 8'd10;
        seen_high = 1'b0;
        pwm_in[3] = 1'b1;
        repeat (4) tick();
        check("en_dead_low", out_low[3], 0);
        check("en_dead_en",  out_en[3],  1);
        pwm_en_in[3] = 1'b0;
        tick();
        check("en_off_en",  out_en[3],  0);
        check("en_off_low", out_low[3], 0);
        for (int k = 0; k < 12; k++) begin
            seen_high |= out_high[3];
            tick();
        end
        check("en_no_high", seen_high, 0);

        check("never_overlap", overlap_acc, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
